// File: rtl/hazard_pkg.sv
// Shared types and parameter limits for the multi-cycle hazard unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mc_state_t;

  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 3;
  localparam int MC_LAT_MIN   = 1;
  localparam int MC_LAT_MAX   = 32;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hazard_unit_mc_fsm.sv
// Multi-cycle Execute stall FSM: holds the pipe while a long op
// occupies Execute, then releases it for one DONE cycle.
module mc_stall_fsm
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mc_start_e,
  input  logic pcsrc_e,
  output logic mc_stall,
  output logic mc_busy,
  output logic mc_done
);

  localparam int LAT = clamp(MC_LAT, MC_LAT_MIN, MC_LAT_MAX);
  localparam int CW  = cnt_bits(LAT);
  localparam logic [CW-1:0] LOAD = CW'((LAT > 2) ? LAT - 2 : 0);

  mc_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mc_stall = 1'b0;
    mc_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (mc_start_e && LAT > 1 && !pcsrc_e) begin
          mc_stall = 1'b1;
          if (LAT == 2) begin
            state_nx = DONE;
          end else begin
            state_nx = BUSY;
            cnt_nx   = LOAD;
          end
        end
      end
      BUSY: begin
        mc_stall = 1'b1;
        cnt_nx   = cnt - CW'(1);
        if (cnt == CW'(1)) state_nx = DONE;
      end
      DONE: begin
        mc_done  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (!rst) begin
      mc_stall = 1'b0;
      mc_done  = 1'b0;
    end
  end

  assign mc_busy = mc_stall;

endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: forwarding, multi-bubble load-use,
// multi-cycle Execute stalls and saturating perf counters.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MC_LAT   = 4,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              mem_read_e,
  input  logic              pcsrc_e,
  input  logic              mc_start_e,
  input  logic              cnt_clr,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic [1:0]        forward_ae,
  output logic [1:0]        forward_be,
  output logic              mc_busy,
  output logic              mc_done,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int LL = clamp(LOAD_LAT, LOAD_LAT_MIN, LOAD_LAT_MAX);
  localparam logic [1:0] LU_LOAD = 2'(LL - 1);

  logic       mc_stall;
  logic       lu_hit;
  logic       lu_act;
  logic       br_flush;
  logic [1:0] lu_cnt;

  mc_stall_fsm #(
    .MC_LAT(MC_LAT)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .mc_start_e(mc_start_e),
    .pcsrc_e   (pcsrc_e),
    .mc_stall  (mc_stall),
    .mc_busy   (mc_busy),
    .mc_done   (mc_done)
  );

  function automatic fwd_sel_t fwd(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] dm,
    input logic [REG_AW-1:0] dw,
    input logic              wm,
    input logic              ww
  );
    if (wm && dm != '0 && dm == rs) return FWD_M;
    if (ww && dw != '0 && dw == rs) return FWD_W;
    return FWD_RF;
  endfunction

  assign forward_ae = rst ? fwd(rs1_e, rd_m, rd_w, reg_write_m, reg_write_w) : FWD_RF;
  assign forward_be = rst ? fwd(rs2_e, rd_m, rd_w, reg_write_m, reg_write_w) : FWD_RF;

  assign lu_hit   = mem_read_e && rd_e != '0 &&
                    (rd_e == rs1_d || rd_e == rs2_d);
  assign lu_act   = lu_hit || lu_cnt != 2'd0;
  assign br_flush = rst && pcsrc_e && !mc_stall;

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    priority case (1'b1)
      !rst: ;
      mc_stall: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end
      pcsrc_e: begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
      lu_act: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      default: ;
    endcase
  end

  // A long op freezes the bubble countdown; a branch discards it.
  always_ff @(posedge clk) begin
    if (!rst)                lu_cnt <= '0;
    else if (mc_stall)       lu_cnt <= lu_cnt;
    else if (pcsrc_e)        lu_cnt <= '0;
    else if (lu_hit)         lu_cnt <= LU_LOAD;
    else if (lu_cnt != 2'd0) lu_cnt <= lu_cnt - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_e && br_flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: two configurations share stimulus.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       reg_write_m, reg_write_w, mem_read_e, pcsrc_e;
  logic       mc_start_e, cnt_clr;

  logic       a_stall_f, a_stall_d, a_stall_e;
  logic       a_flush_d, a_flush_e, a_flush_m;
  logic [1:0] a_fwd_a, a_fwd_b;
  logic       a_mc_busy, a_mc_done;
  logic [3:0] a_stall_cnt, a_flush_cnt;

  logic        b_stall_f, b_stall_d, b_stall_e;
  logic        b_flush_d, b_flush_e, b_flush_m;
  logic [1:0]  b_fwd_a, b_fwd_b;
  logic        b_mc_busy, b_mc_done;
  logic [31:0] b_stall_cnt, b_flush_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(
    .REG_AW(5), .LOAD_LAT(2), .MC_LAT(4), .CNT_W(4)
  ) u_a (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_read_e(mem_read_e), .pcsrc_e(pcsrc_e),
    .mc_start_e(mc_start_e), .cnt_clr(cnt_clr),
    .stall_f(a_stall_f), .stall_d(a_stall_d), .stall_e(a_stall_e),
    .flush_d(a_flush_d), .flush_e(a_flush_e), .flush_m(a_flush_m),
    .forward_ae(a_fwd_a), .forward_be(a_fwd_b),
    .mc_busy(a_mc_busy), .mc_done(a_mc_done),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  hazard_unit_mc #(
    .REG_AW(5), .LOAD_LAT(1), .MC_LAT(1), .CNT_W(32)
  ) u_b (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_read_e(mem_read_e), .pcsrc_e(pcsrc_e),
    .mc_start_e(mc_start_e), .cnt_clr(cnt_clr),
    .stall_f(b_stall_f), .stall_d(b_stall_d), .stall_e(b_stall_e),
    .flush_d(b_flush_d), .flush_e(b_flush_e), .flush_m(b_flush_m),
    .forward_ae(b_fwd_a), .forward_be(b_fwd_b),
    .mc_busy(b_mc_busy), .mc_done(b_mc_done),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  typedef struct {
    logic [4:0] rs1_e, rs2_e, rd_m, rd_w;
    logic       wm, ww;
    logic [1:0] ea, eb;
  } fv_t;

  fv_t vec[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
    rd_e = 0; rd_m = 0; rd_w = 0;
    reg_write_m = 0; reg_write_w = 0;
    mem_read_e = 0; pcsrc_e = 0; mc_start_e = 0; cnt_clr = 0;
  endtask

  task automatic settle();
    idle();
    cnt_clr = 1; tick();
    tick();
    cnt_clr = 0; tick();
  endtask

  initial begin
    vec[0] = '{5'd5,  5'd0,  5'd5,  5'd5,  1'b1, 1'b1, 2'b10, 2'b00};
    vec[1] = '{5'd5,  5'd0,  5'd5,  5'd5,  1'b0, 1'b1, 2'b01, 2'b00};
    vec[2] = '{5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 2'b00, 2'b00};
    vec[3] = '{5'd7,  5'd3,  5'd3,  5'd7,  1'b1, 1'b1, 2'b01, 2'b10};
    vec[4] = '{5'd9,  5'd9,  5'd9,  5'd9,  1'b1, 1'b0, 2'b10, 2'b10};
    vec[5] = '{5'd4,  5'd4,  5'd4,  5'd4,  1'b0, 1'b0, 2'b00, 2'b00};
    vec[6] = '{5'd30, 5'd31, 5'd31, 5'd30, 1'b1, 1'b1, 2'b01, 2'b10};

    // Reset: hazards present but everything held low.
    idle();
    rst = 0;
    tick();
    mem_read_e = 1; rd_e = 6; rs2_d = 6; pcsrc_e = 1; mc_start_e = 1;
    rd_m = 5; rs1_e = 5; reg_write_m = 1;
    @(negedge clk);
    chk("rst_stall_f", a_stall_f, 0);
    chk("rst_flush_e", a_flush_e, 0);
    chk("rst_flush_d", a_flush_d, 0);
    chk("rst_stall_e", a_stall_e, 0);
    chk("rst_mc_busy", a_mc_busy, 0);
    chk("rst_fwd_a", a_fwd_a, 0);
    chk("rst_stall_cnt", a_stall_cnt, 0);
    tick();
    idle();
    rst = 1;
    tick();

    // Forwarding table.
    for (int i = 0; i < 7; i++) begin
      rs1_e = vec[i].rs1_e; rs2_e = vec[i].rs2_e;
      rd_m = vec[i].rd_m; rd_w = vec[i].rd_w;
      reg_write_m = vec[i].wm; reg_write_w = vec[i].ww;
      @(negedge clk);
      chk($sformatf("fwd_a[%0d]", i), a_fwd_a, vec[i].ea);
      chk($sformatf("fwd_b[%0d]", i), a_fwd_b, vec[i].eb);
      chk($sformatf("fwd_a_b[%0d]", i), b_fwd_a, vec[i].ea);
      tick();
    end

    // Load-use with two bubbles.
    settle();
    mem_read_e = 1; rd_e = 6; rs1_d = 1; rs2_d = 6;
    @(negedge clk);
    chk("lu0_stall_f", a_stall_f, 1);
    chk("lu0_stall_d", a_stall_d, 1);
    chk("lu0_flush_e", a_flush_e, 1);
    chk("lu0_flush_d", a_flush_d, 0);
    chk("lu0_stall_e", a_stall_e, 0);
    tick();
    mem_read_e = 0; rd_e = 0;
    @(negedge clk);
    chk("lu1_stall_f", a_stall_f, 1);
    chk("lu1_flush_e", a_flush_e, 1);
    chk("lu1_b_stall_f", b_stall_f, 0);
    tick();
    @(negedge clk);
    chk("lu2_stall_f", a_stall_f, 0);
    chk("lu_stall_cnt", a_stall_cnt, 2);
    chk("lu_b_stall_cnt", b_stall_cnt, 1);

    // Branch coinciding with a load-use hazard.
    settle();
    mem_read_e = 1; rd_e = 6; rs2_d = 6; pcsrc_e = 1;
    @(negedge clk);
    chk("br_flush_d", a_flush_d, 1);
    chk("br_flush_e", a_flush_e, 1);
    chk("br_stall_f", a_stall_f, 0);
    chk("br_stall_d", a_stall_d, 0);
    tick();
    idle();
    @(negedge clk);
    chk("br_post_stall_f", a_stall_f, 0);
    chk("br_flush_cnt", a_flush_cnt, 1);
    chk("br_stall_cnt", a_stall_cnt, 0);

    // Multi-cycle op, branch ignored while busy.
    settle();
    mc_start_e = 1;
    for (int k = 0; k < 3; k++) begin
      pcsrc_e = (k == 1);
      @(negedge clk);
      chk($sformatf("mc%0d_stall_e", k), a_stall_e, 1);
      chk($sformatf("mc%0d_flush_m", k), a_flush_m, 1);
      chk($sformatf("mc%0d_busy", k), a_mc_busy, 1);
      chk($sformatf("mc%0d_stall_f", k), a_stall_f, 1);
      chk($sformatf("mc%0d_flush_e", k), a_flush_e, 0);
      chk($sformatf("mc%0d_flush_d", k), a_flush_d, 0);
      chk($sformatf("mc%0d_done", k), a_mc_done, 0);
      chk($sformatf("mc%0d_b_stall_e", k), b_stall_e, 0);
      chk($sformatf("mc%0d_b_busy", k), b_mc_busy, 0);
      tick();
    end
    pcsrc_e = 0;
    @(negedge clk);
    chk("mc3_done", a_mc_done, 1);
    chk("mc3_stall_e", a_stall_e, 0);
    chk("mc3_busy", a_mc_busy, 0);
    chk("mc3_b_done", b_mc_done, 0);
    tick();
    mc_start_e = 0;
    @(negedge clk);
    chk("mc4_done", a_mc_done, 0);
    chk("mc4_busy", a_mc_busy, 0);
    chk("mc_stall_cnt", a_stall_cnt, 3);
    chk("mc_flush_cnt", a_flush_cnt, 0);

    // Reset during the second BUSY cycle.
    settle();
    mc_start_e = 1;
    tick();
    tick();
    rst = 0;
    @(negedge clk);
    chk("mrst_busy", a_mc_busy, 0);
    chk("mrst_stall_e", a_stall_e, 0);
    tick();
    rst = 1; mc_start_e = 0;
    @(negedge clk);
    chk("mrst_post_done", a_mc_done, 0);
    chk("mrst_post_busy", a_mc_busy, 0);
    chk("mrst_stall_cnt", a_stall_cnt, 0);

    // Saturation and clear-wins.
    settle();
    mem_read_e = 1; rd_e = 6; rs1_d = 6;
    repeat (20) tick();
    @(negedge clk);
    chk("sat_stall_cnt", a_stall_cnt, 15);
    chk("sat_b_stall_cnt", b_stall_cnt, 20);
    tick();
    cnt_clr = 1;
    tick();
    cnt_clr = 0; mem_read_e = 0; rd_e = 0;
    @(negedge clk);
    chk("clr_stall_cnt", a_stall_cnt, 0);
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised successor to the 5-stage pipeline hazard unit.
- Adds three capabilities:
  - configurable load-use bubble depth, for synchronous-read data memories;
  - a multi-cycle Execute stall FSM, for MUL/DIV-style units;
  - saturating stall/flush performance counters.
- Sits beside the IF/ID/EX/MEM/WB stages. Drives stall/flush into the IF, IFID, IDEX and ExMem regs, and forward selects into Execute.

Parameters:
- REG_AW, 5, register-address width.
- LOAD_LAT, 1, load-use bubbles inserted per hazard (1..3).
- MC_LAT, 4, cycles a multi-cycle instruction occupies Execute (1..32; 1 disables the FSM).
- CNT_W, 32, perf-counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- rs1_d, rs2_d  in  REG_AW  Decode source regs
- rs1_e, rs2_e, rd_e  in  REG_AW  Execute regs
- rd_m  in  REG_AW  Memory dest
- rd_w  in  REG_AW  Writeback dest
- reg_write_m, reg_write_w  in  1  write enables
- mem_read_e  in  1  load in Execute
- pcsrc_e  in  1  taken branch/jump in Execute
- mc_start_e  in  1  multi-cycle instruction in Execute
- cnt_clr  in  1  clear perf counters
- stall_f, stall_d, stall_e  out  1  hold PC, IFID, IDEX
- flush_d, flush_e, flush_m  out  1  bubble into IFID, IDEX, ExMem
- forward_ae, forward_be  out  2  00 regfile, 01 W, 10 M
- mc_busy  out  1  multi-cycle stall active
- mc_done  out  1  release cycle of a multi-cycle instruction
- stall_cnt, flush_cnt  out  CNT_W  perf counters

Behaviour:
- Reset: when rst=0 at a clk edge, FSM goes to IDLE and lu_cnt, stall_cnt, flush_cnt go to 0. While rst=0, all stall/flush outputs and mc_busy/mc_done are 0, and forward selects are 00. Reset mid-stall abandons the stall immediately.
- Forwarding (combinational, zero latency):
  - forward_ae=10 if reg_write_m & rd_m!=0 & rd_m==rs1_e.
  - Else forward_ae=01 if reg_write_w & rd_w!=0 & rd_w==rs1_e.
  - Else forward_ae=00.
  - forward_be follows the same rules with rs2_e. M has priority over W.
- Load-use detect: lu_hit = mem_read_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
  - lu_hit asserts stall_f, stall_d and flush_e in the same cycle.
  - If LOAD_LAT>1, lu_cnt loads LOAD_LAT-1 on lu_hit and decrements each cycle. While lu_cnt!=0, stall_f/stall_d/flush_e stay asserted.
  - Total bubbles per hazard = LOAD_LAT.
- Control hazard: pcsrc_e asserts flush_d and flush_e.
  - It overrides load-use: stall_f/stall_d are 0 and lu_cnt clears to 0.
  - It is ignored while mc_busy=1; multi-cycle ops are never branches.
- Multi-cycle FSM, states IDLE, BUSY, DONE, with counter mc_cnt of width $clog2(MC_LAT):
  - IDLE: if mc_start_e & MC_LAT>1 & !pcsrc_e, stall this cycle. If MC_LAT==2, next state is DONE; otherwise next state is BUSY with mc_cnt=MC_LAT-2.
  - BUSY: stall and decrement mc_cnt. When mc_cnt==1, next state is DONE.
  - DONE: no stall, mc_done=1, next state is IDLE. The still-asserted mc_start_e is ignored in DONE.
  - mc stall asserts stall_f, stall_d, stall_e, flush_m and mc_busy. It forces flush_e=0 and flush_d=0.
  - Stall cycles = MC_LAT-1; Execute occupancy = MC_LAT cycles.
- Operand capture: the multi-cycle unit latches its operands in the start cycle. Forward selects after the start cycle are don't-care.
- Priority, highest first: reset > mc stall > pcsrc_e flush > load-use.
- Perf counters:
  - stall_cnt +1 on each cycle with stall_f=1.
  - flush_cnt +1 on each cycle with flush_e=1 caused by pcsrc_e.
  - Both saturate at all-ones.
  - cnt_clr zeroes both next cycle; if cnt_clr coincides with an increment event, clear wins.

Decomposition:
- hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - mc_state_t enum: IDLE, BUSY, DONE.
  - Parameter range-check localparams.
- One sub-module, mc_stall_fsm: FSM plus mc_cnt, with outputs mc_stall, mc_busy, mc_done.
- Forwarding logic, load-use logic and perf counters stay in the parent.

Test Plan:
- Forwarding: rd_m=rd_w=5, both write, rs1_e=5 -> forward_ae=10. Set reg_write_m=0 -> forward_ae=01. Set rd_m=rd_w=0 -> 00.
- Load-use, LOAD_LAT=2: lw x6 in E, rs2_d=6 -> stall_f/stall_d/flush_e high for exactly 2 cycles, then stall_cnt=2.
- Branch during load-use: lu_hit and pcsrc_e in the same cycle -> flush_d=flush_e=1, stall_f=0, lu_cnt=0 next cycle, flush_cnt=1.
- Multi-cycle, MC_LAT=4: mc_start_e held -> stall_e and flush_m high for 3 cycles, mc_done on the 4th, IDLE after, no restart. MC_LAT=1 -> no stall.
- Reset mid-BUSY: drive rst=0 in the second BUSY cycle -> next cycle state is IDLE, all stalls 0, counters 0.
- Saturation, CNT_W=4: 20 stall cycles -> stall_cnt=15. cnt_clr plus stall in the same cycle -> 0.
